// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM encoding and default geometry for the Wishbone arbiter slice.
package wb_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1, ST_ABORT} state_t;
   localparam int WB_ADR_W = 26;
   localparam int WB_DAT_W = 32;
   localparam int WB_TMO   = 255;
endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: counts consecutive unacked strobe cycles and flags the TMO-th one.
module wb_watchdog import wb_pkg::*; #(
   parameter int TMO = WB_TMO
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   input  logic clr_i,
   output logic expire_o
);
   localparam logic [7:0] LIM = 8'(TMO - 1);
   logic [7:0] cnt_q, cnt_d;
   // compare against TMO-1 so the flag lands on the TMO-th cycle itself; an ack that cycle wins
   assign expire_o = run_i & ~clr_i & (cnt_q == LIM);
   assign cnt_d = (~run_i | clr_i | expire_o) ? 8'd0 : cnt_q + 8'd1;
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin Wishbone arbiter with burst-hold ownership
// and a bus-timeout abort path.
module wb_rr_arbiter import wb_pkg::*; #(
   parameter int ADR_W = WB_ADR_W,
   parameter int DAT_W = WB_DAT_W,
   parameter int TMO   = WB_TMO
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [DAT_W-1:0] m0_dat_i,
   input  logic             m0_tagn_i,
   output logic [DAT_W-1:0] m0_dat_o,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   output logic             m0_tagn_o,
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [DAT_W-1:0] m1_dat_i,
   input  logic             m1_tagn_i,
   output logic [DAT_W-1:0] m1_dat_o,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   output logic             m1_tagn_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic             s_tagn_o,
   output logic [ADR_W-1:0] s_adr_o,
   output logic [DAT_W-1:0] s_dat_o,
   input  logic [DAT_W-1:0] s_dat_i,
   input  logic             s_ack_i,
   input  logic             s_tagn_i,
   output logic [1:0]       gnt_o
);
   state_t state_q, state_d;
   logic   last_q, last_d;
   logic   own0, own1, abort, owner_cyc, expire;
   assign own0  = state_q == ST_OWN0;
   assign own1  = state_q == ST_OWN1;
   assign abort = state_q == ST_ABORT;
   // last always names the current owner while one exists
   assign owner_cyc = last_q ? m1_cyc_i : m0_cyc_i;
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (m0_cyc_i | m1_cyc_i) begin
               last_d  = (m0_cyc_i & m1_cyc_i) ? ~last_q : m1_cyc_i;
               state_d = last_d ? ST_OWN1 : ST_OWN0;
            end
         end
         ST_OWN0, ST_OWN1: state_d = !owner_cyc ? ST_IDLE : expire ? ST_ABORT : state_q;
         default:          state_d = owner_cyc ? ST_ABORT : ST_IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end
   wb_watchdog #(.TMO(TMO)) u_wdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .run_i   (s_stb_o),
      .clr_i   (s_ack_i),
      .expire_o(expire)
   );
   assign s_cyc_o  = own0 ? m0_cyc_i  : own1 ? m1_cyc_i  : 1'b0;
   assign s_stb_o  = own0 ? m0_stb_i  : own1 ? m1_stb_i  : 1'b0;
   assign s_we_o   = own0 ? m0_we_i   : own1 ? m1_we_i   : 1'b0;
   assign s_tagn_o = own0 ? m0_tagn_i : own1 ? m1_tagn_i : 1'b0;
   assign s_adr_o  = own0 ? m0_adr_i  : own1 ? m1_adr_i  : '0;
   assign s_dat_o  = own0 ? m0_dat_i  : own1 ? m1_dat_i  : '0;
   assign m0_ack_o  = own0 & s_ack_i;
   assign m1_ack_o  = own1 & s_ack_i;
   assign m0_tagn_o = own0 & s_tagn_i;
   assign m1_tagn_o = own1 & s_tagn_i;
   assign m0_dat_o  = own0 ? s_dat_i : '0;
   assign m1_dat_o  = own1 ? s_dat_i : '0;
   // err only when the abort is actually taken; a pending reset suppresses it
   assign m0_err_o = own0 & expire & m0_cyc_i & ~rst_i;
   assign m1_err_o = own1 & expire & m1_cyc_i & ~rst_i;
   assign gnt_o = {own1 | (abort & last_q), own0 | (abort & ~last_q)};
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed vector table plus randomized run against a behavioural model.
module tb_wb_rr_arbiter;
   localparam int AW  = 26;
   localparam int DW  = 32;
   localparam int TMO = 4;
   typedef struct packed {logic rst, c0, s0, w0, c1, s1, w1, ack;} in_t;
   typedef struct packed {logic [1:0] gnt; logic scyc, sstb, swe, a0, a1, e0, e1;} out_t;
   typedef struct packed {in_t i; out_t o;} vec_t;
   logic clk = 1'b0;
   logic rst_i;
   logic m0_cyc_i, m0_stb_i, m0_we_i, m0_tagn_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_tagn_i;
   logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
   logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic m0_ack_o, m0_err_o, m0_tagn_o, m1_ack_o, m1_err_o, m1_tagn_o;
   logic s_cyc_o, s_stb_o, s_we_o, s_tagn_o, s_ack_i, s_tagn_i;
   logic [1:0] gnt_o;
   int tests = 0, fails = 0, cyc_no = 0;
   vec_t tbl[$];
   // reference model state: owner index (-1 none), abort flag, last grant, unacked streak
   int m_owner = -1, m_last = 1, m_streak = 0;
   bit m_abort = 1'b0;
   always #5 clk = ~clk;
   wb_rr_arbiter #(.ADR_W(AW), .DAT_W(DW), .TMO(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i), .m0_tagn_i(m0_tagn_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o), .m0_tagn_o(m0_tagn_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i), .m1_tagn_i(m1_tagn_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o), .m1_tagn_o(m1_tagn_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_tagn_o(s_tagn_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_tagn_i(s_tagn_i), .gnt_o(gnt_o)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, exp);
      end
   endtask
   task automatic add(input in_t i, input out_t o);
      tbl.push_back({i, o});
   endtask
   task automatic drive(input in_t i);
      rst_i = i.rst; s_ack_i = i.ack;
      m0_cyc_i = i.c0; m0_stb_i = i.s0; m0_we_i = i.w0;
      m1_cyc_i = i.c1; m1_stb_i = i.s1; m1_we_i = i.w1;
   endtask
   task automatic check(input out_t e);
      chk("gnt", 32'(gnt_o), 32'(e.gnt));
      chk("s_cyc", 32'(s_cyc_o), 32'(e.scyc));
      chk("s_stb", 32'(s_stb_o), 32'(e.sstb));
      chk("s_we", 32'(s_we_o), 32'(e.swe));
      chk("m0_ack", 32'(m0_ack_o), 32'(e.a0));
      chk("m1_ack", 32'(m1_ack_o), 32'(e.a1));
      chk("m0_err", 32'(m0_err_o), 32'(e.e0));
      chk("m1_err", 32'(m1_err_o), 32'(e.e1));
      if (e.scyc) begin
         chk("s_adr", 32'(s_adr_o), 32'(e.gnt == 2'b01 ? m0_adr_i : m1_adr_i));
         chk("s_dat", s_dat_o, e.gnt == 2'b01 ? m0_dat_i : m1_dat_i);
         chk("s_tagn", 32'(s_tagn_o), 32'(e.gnt == 2'b01 ? m0_tagn_i : m1_tagn_i));
      end
      if (e.gnt == 2'b00) begin
         chk("s_adr_idle", 32'(s_adr_o), 32'd0);
         chk("s_dat_idle", s_dat_o, 32'd0);
      end
      if (!e.gnt[0]) chk("m0_dat_quiet", m0_dat_o, 32'd0);
      if (!e.gnt[1]) chk("m1_dat_quiet", m1_dat_o, 32'd0);
      if (e.a0) chk("m0_dat", m0_dat_o, s_dat_i);
      if (e.a1) chk("m1_dat", m1_dat_o, s_dat_i);
   endtask
   task automatic step(input in_t i, input out_t e);
      drive(i);
      #4;
      check(e);
      @(posedge clk);
      #1;
      cyc_no++;
   endtask
   function automatic out_t model_out(input in_t i);
      out_t e;
      bit in_own, oc, os, ow;
      in_own = m_owner >= 0 && !m_abort;
      oc = m_owner == 1 ? i.c1 : i.c0;
      os = m_owner == 1 ? i.s1 : i.s0;
      ow = m_owner == 1 ? i.w1 : i.w0;
      e = '0;
      e.gnt  = m_owner < 0 ? 2'b00 : m_owner == 0 ? 2'b01 : 2'b10;
      e.scyc = in_own && oc;
      e.sstb = in_own && os;
      e.swe  = in_own && ow;
      e.a0   = in_own && m_owner == 0 && i.ack;
      e.a1   = in_own && m_owner == 1 && i.ack;
      e.e0   = in_own && m_owner == 0 && oc && os && !i.ack && m_streak + 1 == TMO && !i.rst;
      e.e1   = in_own && m_owner == 1 && oc && os && !i.ack && m_streak + 1 == TMO && !i.rst;
      return e;
   endfunction
   task automatic model_step(input in_t i, input out_t e);
      bit oc, os;
      oc = m_owner == 1 ? i.c1 : i.c0;
      os = m_owner == 1 ? i.s1 : i.s0;
      if (i.rst) begin
         m_owner = -1; m_abort = 1'b0; m_last = 1; m_streak = 0;
      end else if (m_owner < 0) begin
         if (i.c0 || i.c1) begin
            m_owner = (i.c0 && i.c1) ? 1 - m_last : (i.c0 ? 0 : 1);
            m_last = m_owner;
            m_streak = 0;
         end
      end else if (m_abort) begin
         if (!oc) begin m_owner = -1; m_abort = 1'b0; end
      end else if (!oc) begin
         m_owner = -1; m_streak = 0;
      end else if (e.e0 || e.e1) begin
         m_abort = 1'b1; m_streak = 0;
      end else begin
         m_streak = (os && !i.ack) ? m_streak + 1 : 0;
      end
   endtask
   initial begin
      in_t ri;
      out_t re;
      bit c0r = 1'b0, c1r = 1'b0;
      // reset/idle, m0 single write
      add(8'b1_000_000_0, 9'b00_000_0000);
      add(8'b0_000_000_0, 9'b00_000_0000);
      add(8'b0_111_000_0, 9'b00_000_0000);
      add(8'b0_111_000_0, 9'b01_111_0000);
      add(8'b0_111_000_1, 9'b01_111_1000);
      add(8'b0_000_000_0, 9'b01_000_0000);
      add(8'b0_000_000_0, 9'b00_000_0000);
      // three ties in a row: m0, m1, m0 with one dead cycle between owners
      add(8'b1_000_000_0, 9'b00_000_0000);
      add(8'b0_110_110_0, 9'b00_000_0000);
      add(8'b0_110_110_1, 9'b01_110_1000);
      add(8'b0_110_110_1, 9'b01_110_1000);
      add(8'b0_000_110_0, 9'b01_000_0000);
      add(8'b0_110_110_0, 9'b00_000_0000);
      add(8'b0_110_110_1, 9'b10_110_0100);
      add(8'b0_110_110_1, 9'b10_110_0100);
      add(8'b0_110_000_0, 9'b10_000_0000);
      add(8'b0_110_110_0, 9'b00_000_0000);
      add(8'b0_110_110_1, 9'b01_110_1000);
      add(8'b0_110_110_1, 9'b01_110_1000);
      add(8'b0_000_000_0, 9'b01_000_0000);
      add(8'b0_000_000_0, 9'b00_000_0000);
      // m1 owns, m0 waits mid-burst
      add(8'b0_000_110_0, 9'b00_000_0000);
      add(8'b0_000_110_1, 9'b10_110_0100);
      add(8'b0_111_110_1, 9'b10_110_0100);
      add(8'b0_111_110_1, 9'b10_110_0100);
      add(8'b0_111_000_0, 9'b10_000_0000);
      add(8'b0_111_000_0, 9'b00_000_0000);
      add(8'b0_111_000_1, 9'b01_111_1000);
      add(8'b0_000_000_0, 9'b01_000_0000);
      add(8'b0_000_000_0, 9'b00_000_0000);
      // timeout on the 4th unacked strobe, late ack dropped, then m1 served
      add(8'b0_110_000_0, 9'b00_000_0000);
      add(8'b0_110_000_0, 9'b01_110_0000);
      add(8'b0_110_000_0, 9'b01_110_0000);
      add(8'b0_110_000_0, 9'b01_110_0000);
      add(8'b0_110_000_0, 9'b01_110_0010);
      add(8'b0_110_110_1, 9'b01_000_0000);
      add(8'b0_110_110_0, 9'b01_000_0000);
      add(8'b0_000_110_0, 9'b01_000_0000);
      add(8'b0_000_110_0, 9'b00_000_0000);
      add(8'b0_000_110_1, 9'b10_110_0100);
      add(8'b0_000_000_0, 9'b10_000_0000);
      add(8'b0_000_000_0, 9'b00_000_0000);
      // ack on exactly the TMO-th cycle wins
      add(8'b0_110_000_0, 9'b00_000_0000);
      add(8'b0_110_000_0, 9'b01_110_0000);
      add(8'b0_110_000_0, 9'b01_110_0000);
      add(8'b0_110_000_0, 9'b01_110_0000);
      add(8'b0_110_000_1, 9'b01_110_1000);
      add(8'b0_110_000_0, 9'b01_110_0000);
      add(8'b0_110_000_1, 9'b01_110_1000);
      add(8'b0_000_000_0, 9'b01_000_0000);
      add(8'b0_000_000_0, 9'b00_000_0000);
      // reset during an m1 read, then a tie goes to m0
      add(8'b0_000_110_0, 9'b00_000_0000);
      add(8'b0_000_110_0, 9'b10_110_0000);
      add(8'b1_000_110_0, 9'b10_110_0000);
      add(8'b0_110_110_0, 9'b00_000_0000);
      add(8'b0_110_110_0, 9'b01_110_0000);
      add(8'b0_000_000_0, 9'b01_000_0000);
      add(8'b0_000_000_0, 9'b00_000_0000);
      m0_adr_i = 26'h0000100; m0_dat_i = 32'hDEADBEEF; m0_tagn_i = 1'b1;
      m1_adr_i = 26'h0000200; m1_dat_i = 32'h12345678; m1_tagn_i = 1'b0;
      s_dat_i = 32'hCAFEF00D; s_tagn_i = 1'b1;
      drive(8'b1_000_000_0);
      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[k]) step(tbl[k].i, tbl[k].o);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) c0r = !c0r;
         if ($urandom_range(0, 7) == 0) c1r = !c1r;
         ri.rst = n == 0 || $urandom_range(0, 149) == 0;
         ri.c0 = c0r; ri.s0 = c0r && $urandom_range(0, 3) != 0; ri.w0 = 1'($urandom);
         ri.c1 = c1r; ri.s1 = c1r && $urandom_range(0, 3) != 0; ri.w1 = 1'($urandom);
         ri.ack = $urandom_range(0, 3) == 0;
         m0_adr_i = AW'($urandom); m0_dat_i = $urandom; m0_tagn_i = 1'($urandom);
         m1_adr_i = AW'($urandom); m1_dat_i = $urandom; m1_tagn_i = 1'($urandom);
         s_dat_i = $urandom; s_tagn_i = 1'($urandom);
         re = model_out(ri);
         step(ri, re);
         model_step(ri, re);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
